ahb_qos_arbiter: RTL

AHB_QOS_ARBITER -- requirements
Module: ahb_qos_arbiter

---
 rtl/ahb_arb_pkg.sv | 55 +++++
 rtl/ahb_defs.sv | 8 +
 rtl/ahb_rr_pick.sv | 30 +++
 rtl/ahb_qos_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Arbiter FSM states, AHB HTRANS/HBURST/HRESP encodings and the fixed-burst length helper.
`include "ahb_defs.sv"

package ahb_arb_pkg;

    localparam int TRANS_W  = `AHB_TRANS_BITS;
    localparam int BURST_W  = `AHB_BURST_BITS;
    localparam int RESP_W   = `AHB_RESP_BITS;
    localparam int MASTER_W = `AHB_MASTER_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_BURST,
        ST_LOCKED
    } arb_state_e;

    typedef enum logic [TRANS_W-1:0] {
        TRANS_IDLE,
        TRANS_BUSY,
        TRANS_NONSEQ,
        TRANS_SEQ
    } htrans_e;

    typedef enum logic [BURST_W-1:0] {
        BURST_SINGLE,
        BURST_INCR,
        BURST_WRAP4,
        BURST_INCR4,
        BURST_WRAP8,
        BURST_INCR8,
        BURST_WRAP16,
        BURST_INCR16
    } hburst_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY,
        RESP_ERROR,
        RESP_RETRY,
        RESP_SPLIT
    } hresp_e;

    // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_len_m1(input logic [BURST_W-1:0] hburst);
        logic [3:0] len;
        case (hburst_e'(hburst))
            BURST_WRAP4, BURST_INCR4:   len = 4'd3;
            BURST_WRAP8, BURST_INCR8:   len = 4'd7;
            BURST_WRAP16, BURST_INCR16: len = 4'd15;
            default:                    len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_defs.sv
// Shared AHB bus field widths used by every AHB block in this slice.
`ifndef AHB_DEFS_SV
`define AHB_DEFS_SV
`define AHB_TRANS_BITS  2
`define AHB_BURST_BITS  3
`define AHB_RESP_BITS   2
`define AHB_MASTER_BITS 2
`endif

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first requester at or after start index, wrapping 2->0.
// Purely combinational, zero latency.
module ahb_rr_pick (
    input  logic [2:0] req_i,
    input  logic [1:0] start_i,
    output logic [2:0] gnt_o,
    output logic       vld_o
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        gnt_o = 3'b000;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, start_i} + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!found && req_i[idx[1:0]]) begin
                gnt_o[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/ahb_qos_arbiter.sv
// Three-master AHB arbiter with per-master transfer quotas, burst protection and locked tenures.
// Grants registered one cycle after arbitration; HMASTER/HMASTLOCK follow the grant on HREADY=1 edges.
module ahb_qos_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned QUOTA_M1 = 8,
    parameter int unsigned QUOTA_M2 = 8,
    parameter int unsigned QUOTA_M3 = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HBUSREQ_M1,
    input  logic                HBUSREQ_M2,
    input  logic                HBUSREQ_M3,
    input  logic                HLOCK_M1,
    input  logic                HLOCK_M2,
    input  logic                HLOCK_M3,
    input  logic [TRANS_W-1:0]  HTRANS,
    input  logic [BURST_W-1:0]  HBURST,
    input  logic                HREADY,
    input  logic [RESP_W-1:0]   HRESP,
    output logic                HGRANT_M1,
    output logic                HGRANT_M2,
    output logic                HGRANT_M3,
    output logic [MASTER_W-1:0] HMASTER,
    output logic                HMASTLOCK
);

    localparam logic [4:0] QUOTA_SAT = 5'd16;

    logic [2:0]          req, lock;
    logic [2:0]          grant_q, grant_d;
    logic [MASTER_W-1:0] hmaster_q, hmaster_d;
    logic                hmastlock_q, hmastlock_d;
    arb_state_e          state_q, state_d;
    logic [3:0]          beat_q, beat_d;
    logic [4:0]          quota_q, quota_d;
    logic [1:0]          rr_q, rr_d;

    logic                is_nonseq, is_seq, accept, arb_en;
    logic                owner_vld, owner_req, owner_lock;
    logic                quota_left, lock_keep, clr_quota;
    logic [1:0]          owner_idx, pick_start;
    logic [MASTER_W-1:0] owner_num;
    logic [4:0]          owner_quota, spent;
    logic [2:0]          pick_gnt;
    logic                pick_vld;

    assign req        = {HBUSREQ_M3, HBUSREQ_M2, HBUSREQ_M1};
    assign lock       = {HLOCK_M3, HLOCK_M2, HLOCK_M1};
    assign is_nonseq  = (HTRANS == TRANS_NONSEQ);
    assign is_seq     = (HTRANS == TRANS_SEQ);
    assign accept     = HREADY && (is_nonseq || is_seq);
    assign owner_vld  = |grant_q;
    assign owner_req  = |(grant_q & req);
    assign owner_lock = |(grant_q & lock);

    always_comb begin
        owner_idx   = 2'd0;
        owner_quota = 5'd0;
        case (grant_q)
            3'b001: begin owner_idx = 2'd0; owner_quota = 5'(QUOTA_M1); end
            3'b010: begin owner_idx = 2'd1; owner_quota = 5'(QUOTA_M2); end
            3'b100: begin owner_idx = 2'd2; owner_quota = 5'(QUOTA_M3); end
            default: ;
        endcase
    end

    assign owner_num  = owner_vld ? MASTER_W'(owner_idx + 2'd1) : '0;
    assign pick_start = !owner_vld ? rr_q : (owner_idx == 2'd2) ? 2'd0 : owner_idx + 2'd1;

    // The owner's transfer in flight when the grant moves still completes,
    // so the grant is released one transfer before the quota is used up.
    assign spent      = (hmaster_q == owner_num) ? quota_q + {4'd0, accept} : 5'd0;
    assign quota_left = (spent + 5'd1) < owner_quota;

    ahb_rr_pick u_rr_pick (
        .req_i   (req),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .vld_o   (pick_vld)
    );

    // An error wait state abandons the burst so the following HREADY edge re-arbitrates.
    always_comb begin
        beat_d = beat_q;
        if (!HREADY && (HRESP != RESP_OKAY)) begin
            beat_d = 4'd0;
        end else if (accept && is_nonseq) begin
            beat_d = burst_len_m1(HBURST);
        end else if (accept && is_seq && (beat_q != 4'd0)) begin
            beat_d = beat_q - 4'd1;
        end
    end

    assign arb_en = HREADY && (beat_d == 4'd0);

    always_comb begin
        grant_d   = grant_q;
        lock_keep = 1'b0;
        clr_quota = 1'b0;
        if (arb_en) begin
            if (owner_req && owner_lock) begin
                lock_keep = 1'b1;
            end else if (owner_req && quota_left) begin
                grant_d = grant_q;
            end else begin
                grant_d   = pick_vld ? pick_gnt : 3'b000;
                clr_quota = owner_vld && (pick_gnt == grant_q);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        case (grant_d)
            3'b001:  rr_d = 2'd1;
            3'b010:  rr_d = 2'd2;
            3'b100:  rr_d = 2'd0;
            default: ;
        endcase
    end

    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (HREADY) begin
            hmaster_d   = owner_num;
            hmastlock_d = owner_lock;
        end
        quota_d = quota_q;
        if (accept && (quota_q != QUOTA_SAT)) begin
            quota_d = quota_q + 5'd1;
        end
        if ((hmaster_d != hmaster_q) || clr_quota) begin
            quota_d = 5'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (beat_d != 4'd0) begin
            state_d = ST_BURST;
        end else if (arb_en) begin
            if (grant_d == 3'b000) begin
                state_d = ST_IDLE;
            end else if (lock_keep) begin
                state_d = ST_LOCKED;
            end else begin
                state_d = ST_OWN;
            end
        end else if (state_q == ST_BURST) begin
            state_d = ST_OWN;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'b000;
            hmaster_q   <= '0;
            hmastlock_q <= 1'b0;
            beat_q      <= 4'd0;
            quota_q     <= 5'd0;
            rr_q        <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beat_q      <= beat_d;
            quota_q     <= quota_d;
            rr_q        <= rr_d;
        end
    end

    assign HGRANT_M1 = grant_q[0];
    assign HGRANT_M2 = grant_q[1];
    assign HGRANT_M3 = grant_q[2];
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
